engine_scheduler: RTL and testbench
===================================

// Module: engine_scheduler
// PURPOSE
//  Job-level sequencer for the matrix-multiply datapath: on a run request it steps
//  capture -> send -> PE -> SA_3x3 -> SA_2x2 -> display and skips engines masked off.
//  Adds a per-stage watchdog, error reporting and optional per-engine cycle counters.
//  Drives the memory, core_module and display stage-enable levels; consumes their done flags.
// PARAMETERS
//  TIMEOUT       1024  max cycles per stage before watchdog error (>=2)
//  DISPLAY_CYC   4     cycles spent in DISPLAY before job completes (>=1)
//  CNT_W         16    width of watchdog and perf counters
// PORTS
//  clk            in   1      rising-edge clock
//  reset          in   1      asynchronous, active-low reset
//  run            in   1      job request; accepted on 0->1 edge while IDLE
//  clear          in   1      leave ERROR -> IDLE (ignored in other states)
//  cfg_mask       in   3      engine enable {SA_2x2,SA_3x3,PE}; latched at run accept
//  done_capture   in   1      capture complete (sampled only in CAPTURE)
//  done_send      in   1      operand send complete (sampled only in SEND)
//  done_PE        in   1      single-PE result ready (sampled only in PE)
//  done_SA_3x3    in   1      3x3 array result ready (sampled only in SA3)
//  done_SA_2x2    in   1      2x2 array result ready (sampled only in SA2)
//  state_capture/state_send/state_PE/state_SA_3x3/state_SA_2x2/state_display
//                 out  1 ea   one-hot stage-enable levels, high for whole stage
//  current_state  out  3      encoded state, see BEHAVIOUR
//  busy           out  1      high in any state except IDLE and ERROR
//  job_done       out  1      one-cycle pulse on DISPLAY -> IDLE
//  error          out  1      high while in ERROR
//  error_stage    out  3      state code that timed out; held until next run accept
//  cyc_PE/cyc_SA_3x3/cyc_SA_2x2  out CNT_W  cycles spent in each engine (last job)
// BEHAVIOUR
//  - States: IDLE=0 CAPTURE=1 SEND=2 PE=3 SA3=4 SA2=5 DISPLAY=6 ERROR=7; registered Moore.
//  - Reset: state IDLE, all outputs 0, mask 0, counters 0, run-edge register 0.
//  - IDLE: run rising edge (run=1, run_q=0) -> CAPTURE next cycle; latch cfg_mask;
//    clear error_stage. Run held high after a job does NOT restart it.
//  - Stage exit: done of current stage high at a clock edge -> next state on that edge;
//    done flags of non-current stages ignored.
//  - After SEND, next is the first enabled of PE, SA3, SA2 in that order; after each
//    engine, the next enabled one; none left -> DISPLAY. cfg_mask=000: SEND -> DISPLAY.
//  - DISPLAY: fixed DISPLAY_CYC cycles, then IDLE with job_done pulse in the first IDLE cycle.
//  - Watchdog: counter zeroed on every state entry; increments each cycle in
//    CAPTURE..SA2; reaching TIMEOUT-1 without done -> ERROR, error_stage=state.
//    done and timeout in the same cycle: done wins. DISPLAY has no watchdog.
//  - ERROR: all stage enables low; clear=1 -> IDLE (no job_done); run ignored.
//  - cfg_mask changes mid-job have no effect. Reset mid-job: immediate IDLE, enables drop.
// CONFIGURATION
//  ENGINE_PERF_EN defined: cyc_* zeroed at run accept, +1 per cycle in matching state,
//   saturating at 2^CNT_W-1, held after job until next accept.
//  ENGINE_PERF_EN undefined: cyc_* tied to 0, no counter flops.
// STRUCTURE
//  Package engine_sched_pkg: state code localparams, mask bit indices (MASK_PE=0,
//   MASK_SA3=1, MASK_SA2=2), next-engine function.
//  Sub-module stage_watchdog (clk, reset, restart, enable, expired) holds the timeout counter.
// TESTING
//  T1 mask=111, done_* each 3 cycles after stage entry -> visits 1,2,3,4,5,6,0; job_done 1 pulse.
//  T2 mask=010 -> 1,2,4,6,0; state_PE/state_SA_2x2 never high; mask=000 -> 1,2,6,0.
//  T3 done_SA_3x3 never asserted, TIMEOUT=16 -> ERROR 15 cycles after SA3 entry,
//     error_stage=4; clear -> IDLE, no job_done.
//  T4 run held high 100 cycles -> exactly one job; done_PE pulsed during SEND -> ignored.
//  T5 reset low mid-SA3 -> all outputs 0 that cycle; after release run edge starts fresh job.
//  T6 ENGINE_PERF_EN, PE stage 7 cycles -> cyc_PE=7; CNT_W=4, 20-cycle stage -> cyc=15.

Source files
------------

// File: rtl/engine_scheduler_pkg.sv
// Shared state codes, engine mask bit positions and the engine ordering rule
// for the matrix-multiply job scheduler.
package engine_sched_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CAPTURE = 3'd1;
    localparam logic [2:0] ST_SEND    = 3'd2;
    localparam logic [2:0] ST_PE      = 3'd3;
    localparam logic [2:0] ST_SA3     = 3'd4;
    localparam logic [2:0] ST_SA2     = 3'd5;
    localparam logic [2:0] ST_DISPLAY = 3'd6;
    localparam logic [2:0] ST_ERROR   = 3'd7;

    localparam int MASK_PE  = 0;
    localparam int MASK_SA3 = 1;
    localparam int MASK_SA2 = 2;

    // First enabled engine strictly after 'cur' in PE -> SA3 -> SA2 order; DISPLAY when none remain.
    function automatic logic [2:0] next_engine(input logic [2:0] mask, input logic [2:0] cur);
        logic [2:0] nxt;
        nxt = ST_DISPLAY;
        if (cur == ST_SEND) begin
            if (mask[MASK_PE])       nxt = ST_PE;
            else if (mask[MASK_SA3]) nxt = ST_SA3;
            else if (mask[MASK_SA2]) nxt = ST_SA2;
        end else if (cur == ST_PE) begin
            if (mask[MASK_SA3])      nxt = ST_SA3;
            else if (mask[MASK_SA2]) nxt = ST_SA2;
        end else if (cur == ST_SA3) begin
            if (mask[MASK_SA2])      nxt = ST_SA2;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/engine_scheduler_if.sv
// Control bundle between the job scheduler (master) and the datapath stages it sequences (slave).
// Stage enables are levels; done flags are levels sampled only by the matching stage.
interface engine_scheduler_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic             clear;
    logic [2:0]       cfg_mask;
    logic             done_capture;
    logic             done_send;
    logic             done_PE;
    logic             done_SA_3x3;
    logic             done_SA_2x2;
    logic             state_capture;
    logic             state_send;
    logic             state_PE;
    logic             state_SA_3x3;
    logic             state_SA_2x2;
    logic             state_display;
    logic [2:0]       current_state;
    logic             busy;
    logic             job_done;
    logic             error;
    logic [2:0]       error_stage;
    logic [CNT_W-1:0] cyc_PE;
    logic [CNT_W-1:0] cyc_SA_3x3;
    logic [CNT_W-1:0] cyc_SA_2x2;

    modport master (
        input  run, clear, cfg_mask,
        input  done_capture, done_send, done_PE, done_SA_3x3, done_SA_2x2,
        output state_capture, state_send, state_PE, state_SA_3x3, state_SA_2x2, state_display,
        output current_state, busy, job_done, error, error_stage,
        output cyc_PE, cyc_SA_3x3, cyc_SA_2x2
    );

    modport slave (
        output run, clear, cfg_mask,
        output done_capture, done_send, done_PE, done_SA_3x3, done_SA_2x2,
        input  state_capture, state_send, state_PE, state_SA_3x3, state_SA_2x2, state_display,
        input  current_state, busy, job_done, error, error_stage,
        input  cyc_PE, cyc_SA_3x3, cyc_SA_2x2
    );

endinterface

// File: rtl/engine_scheduler_watchdog.sv
// Per-stage timeout counter: cleared on restart, counts while enabled.
// Latency: expired is combinational, raised in the cycle whose edge would bring the count to TIMEOUT-1.
// Backpressure: none; the owner decides what to do with expired.
module stage_watchdog #(
    parameter int TIMEOUT = 1024,
    parameter int W       = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic enable,
    output logic expired
);

    logic [W-1:0] cnt;

    assign expired = enable && (cnt == W'(TIMEOUT - 2));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/engine_scheduler.sv
// Job sequencer: capture -> send -> enabled engines -> display, with watchdog; ENGINE_PERF_EN adds cycle counters.
// Latency: run edge in IDLE gives CAPTURE next cycle; each done moves on at the edge it is sampled.
// Backpressure: holds a stage enable until its done arrives or the watchdog drops the job into ERROR.
module engine_scheduler
    import engine_sched_pkg::*;
#(
    parameter int TIMEOUT     = 1024,
    parameter int DISPLAY_CYC = 4,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                reset,
    engine_scheduler_if.master  bus
);

    // Watchdog counter must reach TIMEOUT-1 even when CNT_W is narrow.
    localparam int WD_W   = (CNT_W > $clog2(TIMEOUT)) ? CNT_W : $clog2(TIMEOUT);
    localparam int DISP_W = $clog2(DISPLAY_CYC) + 1;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [2:0]        mask;
    logic [2:0]        err_stage;
    logic              run_q;
    logic              job_done_q;
    logic              accept;
    logic              wd_run;
    logic              wd_expired;
    logic [DISP_W-1:0] disp_cnt;

    assign accept = (state == ST_IDLE) && bus.run && !run_q;
    assign wd_run = (state >= ST_CAPTURE) && (state <= ST_SA2);

    // Done is checked before the watchdog so a late-but-valid done still wins.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (accept) state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (bus.done_capture) state_nxt = ST_SEND;
                        else if (wd_expired)  state_nxt = ST_ERROR;
            ST_SEND:    if (bus.done_send)    state_nxt = next_engine(mask, ST_SEND);
                        else if (wd_expired)  state_nxt = ST_ERROR;
            ST_PE:      if (bus.done_PE)      state_nxt = next_engine(mask, ST_PE);
                        else if (wd_expired)  state_nxt = ST_ERROR;
            ST_SA3:     if (bus.done_SA_3x3)  state_nxt = next_engine(mask, ST_SA3);
                        else if (wd_expired)  state_nxt = ST_ERROR;
            ST_SA2:     if (bus.done_SA_2x2)  state_nxt = ST_DISPLAY;
                        else if (wd_expired)  state_nxt = ST_ERROR;
            ST_DISPLAY: if (disp_cnt == DISP_W'(DISPLAY_CYC - 1)) state_nxt = ST_IDLE;
            ST_ERROR:   if (bus.clear) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    stage_watchdog #(
        .TIMEOUT (TIMEOUT),
        .W       (WD_W)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .restart (state_nxt != state),
        .enable  (wd_run),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            run_q      <= 1'b0;
            mask       <= 3'b000;
            err_stage  <= 3'd0;
            job_done_q <= 1'b0;
            disp_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            run_q      <= bus.run;
            job_done_q <= (state == ST_DISPLAY) && (state_nxt == ST_IDLE);
            disp_cnt   <= (state == ST_DISPLAY) ? disp_cnt + 1'b1 : '0;
            if (accept) begin
                mask      <= bus.cfg_mask;
                err_stage <= 3'd0;
            end else if ((state_nxt == ST_ERROR) && (state != ST_ERROR)) begin
                err_stage <= state;
            end
        end
    end

    assign bus.state_capture = (state == ST_CAPTURE);
    assign bus.state_send    = (state == ST_SEND);
    assign bus.state_PE      = (state == ST_PE);
    assign bus.state_SA_3x3  = (state == ST_SA3);
    assign bus.state_SA_2x2  = (state == ST_SA2);
    assign bus.state_display = (state == ST_DISPLAY);
    assign bus.current_state = state;
    assign bus.busy          = (state != ST_IDLE) && (state != ST_ERROR);
    assign bus.job_done      = job_done_q;
    assign bus.error         = (state == ST_ERROR);
    assign bus.error_stage   = err_stage;

`ifdef ENGINE_PERF_EN
    logic [CNT_W-1:0] cyc_pe;
    logic [CNT_W-1:0] cyc_sa3;
    logic [CNT_W-1:0] cyc_sa2;

    // Counters saturate rather than wrap so a long stage never reads as a short one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_pe  <= '0;
            cyc_sa3 <= '0;
            cyc_sa2 <= '0;
        end else if (accept) begin
            cyc_pe  <= '0;
            cyc_sa3 <= '0;
            cyc_sa2 <= '0;
        end else begin
            if ((state == ST_PE)  && (cyc_pe  != '1)) cyc_pe  <= cyc_pe  + 1'b1;
            if ((state == ST_SA3) && (cyc_sa3 != '1)) cyc_sa3 <= cyc_sa3 + 1'b1;
            if ((state == ST_SA2) && (cyc_sa2 != '1)) cyc_sa2 <= cyc_sa2 + 1'b1;
        end
    end

    assign bus.cyc_PE     = cyc_pe;
    assign bus.cyc_SA_3x3 = cyc_sa3;
    assign bus.cyc_SA_2x2 = cyc_sa2;
`else
    assign bus.cyc_PE     = '0;
    assign bus.cyc_SA_3x3 = '0;
    assign bus.cyc_SA_2x2 = '0;
`endif

endmodule

// File: tb/tb_engine_scheduler.sv
// Directed bench for engine_scheduler: stage ordering, masking, watchdog, run-edge, reset and perf counters.
module tb_engine_scheduler;
    import engine_sched_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    engine_scheduler_if #(.CNT_W(16)) bus ();

    engine_scheduler #(
        .TIMEOUT     (16),
        .DISPLAY_CYC (4),
        .CNT_W       (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef ENGINE_PERF_EN
    engine_scheduler_if #(.CNT_W(4)) bus_s ();

    engine_scheduler #(
        .TIMEOUT     (64),
        .DISPLAY_CYC (4),
        .CNT_W       (4)
    ) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    task automatic sat_done(input logic v);
        bus_s.done_capture = v;
        bus_s.done_send    = v;
        bus_s.done_PE      = v;
        bus_s.done_SA_3x3  = v;
        bus_s.done_SA_2x2  = v;
    endtask
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [5:0] enables();
        return {bus.state_display, bus.state_SA_2x2, bus.state_SA_3x3,
                bus.state_PE, bus.state_send, bus.state_capture};
    endfunction

    function automatic logic [5:0] exp_en(input logic [2:0] s);
        logic [5:0] one;
        one = 6'b000001;
        if ((s >= 3'd1) && (s <= 3'd6)) return one << (s - 3'd1);
        return 6'b000000;
    endfunction

    task automatic set_done(input logic [2:0] s, input logic v);
        case (s)
            3'd1:    bus.done_capture = v;
            3'd2:    bus.done_send    = v;
            3'd3:    bus.done_PE      = v;
            3'd4:    bus.done_SA_3x3  = v;
            3'd5:    bus.done_SA_2x2  = v;
            default: ;
        endcase
    endtask

    // Called at the negedge of a stage's first cycle; stage lasts len cycles.
    task automatic stage(input string tag, input logic [2:0] s, input int len);
        chk({tag, "_state"}, 32'(bus.current_state), 32'(s));
        chk({tag, "_en"}, 32'(enables()), 32'(exp_en(s)));
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        repeat (len - 1) tick();
        chk({tag, "_hold"}, 32'(bus.current_state), 32'(s));
        set_done(s, 1'b1);
        tick();
        set_done(s, 1'b0);
    endtask

    task automatic display_phase(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_disp"}, 32'(bus.current_state), 32'd6);
            chk({tag, "_disp_en"}, 32'(enables()), 32'(6'b100000));
            tick();
        end
        chk({tag, "_idle"}, 32'(bus.current_state), 32'd0);
        chk({tag, "_job_done"}, 32'(bus.job_done), 32'd1);
        chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        tick();
        chk({tag, "_job_done_pulse"}, 32'(bus.job_done), 32'd0);
    endtask

    task automatic start_job(input logic [2:0] m);
        bus.run      = 1'b1;
        bus.cfg_mask = m;
        tick();
    endtask

    initial begin
        int bad;
        int pulses;
        reset            = 1'b0;
        bus.run          = 1'b0;
        bus.clear        = 1'b0;
        bus.cfg_mask     = 3'b000;
        bus.done_capture = 1'b0;
        bus.done_send    = 1'b0;
        bus.done_PE      = 1'b0;
        bus.done_SA_3x3  = 1'b0;
        bus.done_SA_2x2  = 1'b0;
`ifdef ENGINE_PERF_EN
        bus_s.run      = 1'b0;
        bus_s.clear    = 1'b0;
        bus_s.cfg_mask = 3'b001;
        sat_done(1'b0);
`endif
        tick();
        tick();
        chk("rst_state", 32'(bus.current_state), 32'd0);
        chk("rst_en", 32'(enables()), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_job_done", 32'(bus.job_done), 32'd0);
        chk("rst_error", 32'(bus.error), 32'd0);
        chk("rst_error_stage", 32'(bus.error_stage), 32'd0);
        chk("rst_cyc_pe", 32'(bus.cyc_PE), 32'd0);
        reset = 1'b1;
        tick();
        chk("idle_no_run", 32'(bus.current_state), 32'd0);

        // T1: all engines enabled, every stage 3 cycles.
        start_job(3'b111);
        bus.run = 1'b0;
        stage("t1_cap", 3'd1, 3);
        stage("t1_send", 3'd2, 3);
        stage("t1_pe", 3'd3, 3);
        stage("t1_sa3", 3'd4, 3);
        stage("t1_sa2", 3'd5, 3);
        display_phase("t1");

        // T2: only SA3 enabled; mask change mid-job must not matter.
        start_job(3'b010);
        bus.run      = 1'b0;
        bus.cfg_mask = 3'b111;
        stage("t2_cap", 3'd1, 3);
        stage("t2_send", 3'd2, 3);
        stage("t2_sa3", 3'd4, 3);
        display_phase("t2");

        start_job(3'b000);
        bus.run = 1'b0;
        stage("t2z_cap", 3'd1, 3);
        stage("t2z_send", 3'd2, 3);
        display_phase("t2z");

        // T3: SA3 never completes -> watchdog at 15 cycles after entry.
        start_job(3'b010);
        bus.run = 1'b0;
        stage("t3_cap", 3'd1, 3);
        stage("t3_send", 3'd2, 3);
        chk("t3_sa3_entry", 32'(bus.current_state), 32'd4);
        repeat (14) tick();
        chk("t3_sa3_last", 32'(bus.current_state), 32'd4);
        tick();
        chk("t3_err_state", 32'(bus.current_state), 32'd7);
        chk("t3_err_flag", 32'(bus.error), 32'd1);
        chk("t3_err_stage", 32'(bus.error_stage), 32'd4);
        chk("t3_err_en", 32'(enables()), 32'd0);
        chk("t3_err_busy", 32'(bus.busy), 32'd0);
        bus.run = 1'b1;
        tick();
        tick();
        chk("t3_run_ignored", 32'(bus.current_state), 32'd7);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk("t3_clear_idle", 32'(bus.current_state), 32'd0);
        chk("t3_no_job_done", 32'(bus.job_done), 32'd0);
        chk("t3_err_cleared", 32'(bus.error), 32'd0);
        chk("t3_stage_held", 32'(bus.error_stage), 32'd4);
        tick();
        chk("t3_run_held_no_start", 32'(bus.current_state), 32'd0);

        // T4: run held high for 100 cycles -> one job; done_PE during SEND ignored.
        bus.run = 1'b0;
        tick();
        start_job(3'b001);
        chk("t4_stage_clr", 32'(bus.error_stage), 32'd0);
        stage("t4_cap", 3'd1, 3);
        chk("t4_send", 32'(bus.current_state), 32'd2);
        bus.done_PE = 1'b1;
        tick();
        bus.done_PE = 1'b0;
        chk("t4_pe_ignored", 32'(bus.current_state), 32'd2);
        bus.done_send = 1'b1;
        tick();
        bus.done_send = 1'b0;
        stage("t4_pe", 3'd3, 2);
        display_phase("t4");
        bad    = 0;
        pulses = 0;
        for (int i = 0; i < 88; i++) begin
            if (bus.current_state != 3'd0) bad++;
            if (bus.job_done) pulses++;
            tick();
        end
        chk("t4_no_restart", 32'(bad), 32'd0);
        chk("t4_no_extra_done", 32'(pulses), 32'd0);

        // T5: reset asserted mid-SA3, then a fresh job.
        bus.run = 1'b0;
        tick();
        start_job(3'b010);
        bus.run = 1'b0;
        stage("t5_cap", 3'd1, 3);
        stage("t5_send", 3'd2, 3);
        tick();
        tick();
        chk("t5_pre_rst", 32'(bus.current_state), 32'd4);
        reset = 1'b0;
        #1;
        chk("t5_rst_state", 32'(bus.current_state), 32'd0);
        chk("t5_rst_en", 32'(enables()), 32'd0);
        chk("t5_rst_busy", 32'(bus.busy), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("t5_idle_after", 32'(bus.current_state), 32'd0);
        start_job(3'b010);
        bus.run = 1'b0;
        stage("t5b_cap", 3'd1, 3);
        stage("t5b_send", 3'd2, 3);
        stage("t5b_sa3", 3'd4, 3);
        display_phase("t5b");

        // T6: PE stage of 7 cycles.
        start_job(3'b001);
        bus.run = 1'b0;
        stage("t6_cap", 3'd1, 3);
        stage("t6_send", 3'd2, 3);
        stage("t6_pe", 3'd3, 7);
        display_phase("t6");
        tick();
`ifdef ENGINE_PERF_EN
        chk("t6_cyc_pe", 32'(bus.cyc_PE), 32'd7);
`else
        chk("t6_cyc_pe", 32'(bus.cyc_PE), 32'd0);
`endif
        chk("t6_cyc_sa3", 32'(bus.cyc_SA_3x3), 32'd0);
        chk("t6_cyc_sa2", 32'(bus.cyc_SA_2x2), 32'd0);

`ifdef ENGINE_PERF_EN
        // 20-cycle PE stage on a 4-bit counter saturates at 15.
        bus_s.run = 1'b1;
        tick();
        chk("sat_capture", 32'(bus_s.current_state), 32'd1);
        sat_done(1'b1);
        tick();
        tick();
        sat_done(1'b0);
        chk("sat_pe_entry", 32'(bus_s.current_state), 32'd3);
        repeat (19) tick();
        chk("sat_pe_last", 32'(bus_s.current_state), 32'd3);
        sat_done(1'b1);
        tick();
        sat_done(1'b0);
        chk("sat_display", 32'(bus_s.current_state), 32'd6);
        repeat (5) tick();
        chk("sat_cyc_pe", 32'(bus_s.cyc_PE), 32'd15);
        chk("sat_cyc_sa3", 32'(bus_s.cyc_SA_3x3), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
